compare_tree_pipe: RTL

//  Pipelined, parametrised magnitude comparator for WIDTH-bit operands, signed or unsigned per transaction.

---
 rtl/compare_pkg.sv | 24 ++
 rtl/cmp_merge2.sv | 12 +
 rtl/compare_tree_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/compare_pkg.sv
// Shared types and node functions for the pipelined magnitude comparator tree.
package compare_pkg;

  typedef struct packed {
    logic more;
    logic less;
  } cmp_flags_t;

  // Combine a higher-significance node with a lower one; the high node wins unless it is equal.
  function automatic cmp_flags_t cmp_merge(input cmp_flags_t hi, input cmp_flags_t lo);
    cmp_flags_t r;
    r.more = hi.more | (!hi.less & lo.more);
    r.less = hi.less | (!hi.more & lo.less);
    return r;
  endfunction

  function automatic cmp_flags_t cmp_leaf(input logic [1:0] a, input logic [1:0] b);
    cmp_flags_t r;
    r.more = (a > b);
    r.less = (a < b);
    return r;
  endfunction

endpackage

// File: rtl/cmp_merge2.sv
// One combinational merge node of the compare tree.
module cmp_merge2
  import compare_pkg::*;
(
  input  cmp_flags_t hi,
  input  cmp_flags_t lo,
  output cmp_flags_t y
);

  assign y = cmp_merge(hi, lo);

endmodule

// File: rtl/compare_tree_pipe.sv
// Pipelined WIDTH-bit magnitude comparator: leaf pairs reduced through a registered binary tree,
// valid/ready on both sides with a per-stage stall chain so bubbles collapse under backpressure.
module compare_tree_pipe
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_more,
  output logic             out_less,
  output logic             out_equal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LAT    = $clog2(WIDTH);
  localparam int unsigned LEAVES = WIDTH / 2;

  // Signed compare becomes unsigned once the sign bits are flipped.
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  assign a_eff = {in_a[WIDTH-1] ^ in_signed, in_a[WIDTH-2:0]};
  assign b_eff = {in_b[WIDTH-1] ^ in_signed, in_b[WIDTH-2:0]};

  for (genvar k = 0; k < LAT; k++) begin : g_stg
    localparam int unsigned N = LEAVES >> k;

    logic                v;
    logic                en;
    logic                src_v;
    logic [TAG_W-1:0]    tag;
    logic [TAG_W-1:0]    src_tag;
    cmp_flags_t [N-1:0]  q;
    cmp_flags_t [N-1:0]  d;

    if (k == 0) begin : g_leaf
      assign src_v   = in_valid;
      assign src_tag = in_tag;
      for (genvar i = 0; i < N; i++) begin : g_node
        assign d[i] = cmp_leaf(a_eff[2*i+1 -: 2], b_eff[2*i+1 -: 2]);
      end
    end else begin : g_merge
      assign src_v   = g_stg[k-1].v;
      assign src_tag = g_stg[k-1].tag;
      for (genvar i = 0; i < N; i++) begin : g_node
        cmp_merge2 u_node (
          .hi (g_stg[k-1].q[2*i+1]),
          .lo (g_stg[k-1].q[2*i]),
          .y  (d[i])
        );
      end
    end

    // A stage may load when it is empty or its contents move on this edge.
    if (k == LAT - 1) begin : g_en_last
      assign en = !v | out_ready;
    end else begin : g_en_mid
      assign en = !v | g_stg[k+1].en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v   <= 1'b0;
        tag <= '0;
        q   <= '0;
      end else if (en) begin
        v <= src_v;
        if (src_v) begin
          tag <= src_tag;
          q   <= d;
        end
      end
    end
  end

  // Equality is captured alongside the final pair so every result flag leaves a flop.
  logic eq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q <= 1'b0;
    end else if (g_stg[LAT-1].en && g_stg[LAT-1].src_v) begin
      eq_q <= !g_stg[LAT-1].d[0].more & !g_stg[LAT-1].d[0].less;
    end
  end

  assign in_ready  = g_stg[0].en;
  assign out_valid = g_stg[LAT-1].v;
  assign out_more  = g_stg[LAT-1].q[0].more;
  assign out_less  = g_stg[LAT-1].q[0].less;
  assign out_equal = eq_q;
  assign out_tag   = g_stg[LAT-1].tag;

endmodule
